// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 device-to-host receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

    typedef enum logic [1:0] {ERR_NONE, ERR_PARITY, ERR_STOP, ERR_TIMEOUT} ps2_err_t;

    localparam int PS2_FRAME_BITS = 11;

endpackage
`default_nettype wire

// File: rtl/ps2_in_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_in_filter
// Description : Pin synchroniser followed by a persistence-count glitch filter.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_in_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level
);

    localparam int              c_CW       = $clog2(GLITCH_CYCLES + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(GLITCH_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_level;

    // Everything resets to the idle-high bus level so release makes no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '1;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            if (r_sync[SYNC_STAGES-1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync[SYNC_STAGES-1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 device-to-host frame receiver with error classification.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TIMEOUT_US    = 2000,
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int              c_DATA_BITS = PS2_FRAME_BITS - 3;
    localparam logic [2:0]      c_LAST_BIT  = 3'(c_DATA_BITS - 1);
    localparam int              c_TCYC      = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int              c_TW        = $clog2(c_TCYC + 1);
    localparam logic [c_TW-1:0] c_TCYC_V    = c_TW'(c_TCYC);

    logic w_clk_f, w_dat, w_fall;
    logic r_clk_prev;

    ps2_rx_state_t   r_state, w_state_next;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_perr;
    logic [c_TW-1:0] r_tcnt;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid, r_rx_err;
    ps2_err_t        r_err_code;

    logic w_timeout, w_bit_clr, w_shift_en, w_perr_ld, w_emit;

    ps2_in_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_clk_filt (
        .clk     (CLOCK_50),
        .rst     (RESET),
        .i_pin   (PS2_CLK),
        .o_level (w_clk_f)
    );

    ps2_in_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_dat_filt (
        .clk     (CLOCK_50),
        .rst     (RESET),
        .i_pin   (PS2_DAT),
        .o_level (w_dat)
    );

    assign w_fall = r_clk_prev & ~w_clk_f;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // A timeout overrides any fall seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_bit_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_perr_ld    = 1'b0;
        w_emit       = 1'b0;
        w_timeout    = (r_state != IDLE) && (r_tcnt == c_TCYC_V);
        if (w_timeout) begin
            w_state_next = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!w_dat) begin
                        w_state_next = DATA;
                        w_bit_clr    = 1'b1;
                    end
                end
                DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) w_state_next = PARITY;
                end
                PARITY: begin
                    w_perr_ld    = 1'b1;
                    w_state_next = STOP;
                end
                STOP: begin
                    w_emit       = 1'b1;
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_clk_prev <= 1'b1;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_tcnt     <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_clk_prev <= w_clk_f;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;

            if (w_bit_clr)       r_bit_cnt <= '0;
            else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_shift_en) r_shift <= {w_dat, r_shift[7:1]};
            // Odd parity: the eight data bits plus parity must hold an odd count of ones.
            if (w_perr_ld)  r_perr  <= ~(^{r_shift, w_dat});

            if (w_fall || r_state == IDLE) r_tcnt <= '0;
            else if (r_tcnt != c_TCYC_V)   r_tcnt <= r_tcnt + c_TW'(1);

            if (w_timeout) begin
                r_rx_err   <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
            end else if (w_emit) begin
                if (r_perr) begin
                    r_rx_err   <= 1'b1;
                    r_err_code <= ERR_PARITY;
                end else if (!w_dat) begin
                    r_rx_err   <= 1'b1;
                    r_err_code <= ERR_STOP;
                end else begin
                    r_rx_valid <= 1'b1;
                    r_rx_data  <= r_shift;
                    r_err_code <= ERR_NONE;
                end
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_err   = r_rx_err;
    assign err_code = r_err_code;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx
// Description : Directed, table-driven self-checking bench for ps2_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

    localparam int CLK_HZ     = 1_000_000;
    localparam int TIMEOUT_US = 300;
    localparam int TCYC       = 300;
    localparam int SYNC       = 2;
    localparam int GLITCH     = 8;
    localparam int HALF       = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [1:0] err_code;
    logic       busy;

    ps2_rx #(
        .CLK_HZ        (CLK_HZ),
        .TIMEOUT_US    (TIMEOUT_US),
        .SYNC_STAGES   (SYNC),
        .GLITCH_CYCLES (GLITCH)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .PS2_CLK  (ps2c),
        .PS2_DAT  (ps2d),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_valid = 0;
    int   n_err   = 0;
    int   n_both  = 0;
    int   n_wide  = 0;
    logic pv      = 1'b0;
    logic pe      = 1'b0;
    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (rx_err) n_err++;
        if (rx_valid && rx_err) n_both++;
        if ((rx_valid && pv) || (rx_err && pe)) n_wide++;
        pv = rx_valid;
        pe = rx_err;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int last_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data settles mid-high; optional 5-cycle inverted blip just before the fall.
    task automatic send_bit(input logic b, input logic glitch);
        ps2d = b;
        wait_cyc(HALF/2 - 8);
        if (glitch) begin
            ps2d = ~b;
            wait_cyc(5);
            ps2d = b;
            wait_cyc(3);
        end else begin
            wait_cyc(8);
        end
        ps2c = 1'b0;
        last_fall = cyc;
        wait_cyc(HALF);
        ps2c = 1'b1;
        wait_cyc(HALF/2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input int glitch_idx);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_idx);
        ps2d = 1'b1;
        wait_cyc(10);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         ev;
        int         ee;
        logic [1:0] code;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int nv, ne, lat, busy_seen;
        logic got;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 2'd0, 8'h1C};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 2'd1, 8'h1C};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, 0, 1, 2'd2, 8'h1C};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1, 0, 2'd0, 8'hA5};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1, 0, 2'd0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1, 0, 2'd0, 8'hFF};
        vecs[6] = '{8'h80, 1'b1, 1'b0, 0, 1, 2'd1, 8'hFF};

        rst  = 1'b1;
        ps2c = 1'b1;
        ps2d = 1'b1;
        wait_cyc(3);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_err", rx_err, 0);
        check("reset_err_code", err_code, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        wait_cyc(20);

        for (int i = 0; i < 7; i++) begin
            nv = n_valid;
            ne = n_err;
            send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, 11, -1);
            wait_cyc(5);
            check($sformatf("vec%0d_valid_pulses", i), n_valid - nv, vecs[i].ev);
            check($sformatf("vec%0d_err_pulses", i), n_err - ne, vecs[i].ee);
            check($sformatf("vec%0d_err_code", i), err_code, vecs[i].code);
            check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end

        // Short low pulse on the idle clock pin must not start a frame.
        busy_seen = 0;
        ps2c = 1'b0;
        wait_cyc(5);
        ps2c = 1'b1;
        for (int i = 0; i < 30; i++) begin
            wait_cyc(1);
            if (busy) busy_seen = 1;
        end
        check("glitch_idle_busy", busy_seen, 0);

        nv = n_valid;
        ne = n_err;
        send_frame(8'h1C, 1'b0, 1'b1, 11, 3);
        wait_cyc(5);
        check("glitch_data_valid", n_valid - nv, 1);
        check("glitch_data_err", n_err - ne, 0);
        check("glitch_data_rx_data", rx_data, 8'h1C);

        // Timeout after start + 4 data bits, then recovery.
        nv = n_valid;
        ne = n_err;
        send_frame(8'h1C, 1'b0, 1'b1, 5, -1);
        check("timeout_busy_mid", busy, 1);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (rx_err) begin
                got = 1'b1;
                lat = cyc - last_fall;
            end
        end
        check("timeout_seen", got, 1);
        check("timeout_err_code", err_code, 3);
        check("timeout_latency_in_window",
              (lat >= TCYC + SYNC + GLITCH - 1) && (lat <= TCYC + SYNC + GLITCH + 3), 1);
        wait_cyc(2);
        check("timeout_busy", busy, 0);
        check("timeout_no_valid", n_valid - nv, 0);
        wait_cyc(100);
        send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
        wait_cyc(5);
        check("recover_valid", n_valid - nv, 1);
        check("recover_err_total", n_err - ne, 1);
        check("recover_rx_data", rx_data, 8'hF0);
        check("recover_err_code", err_code, 0);

        // Reset in the middle of a frame.
        send_frame(8'h1C, 1'b0, 1'b1, 5, -1);
        check("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("rstmid_rx_data", rx_data, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_err_code", err_code, 0);
        check("rstmid_pulses", {30'd0, rx_valid, rx_err}, 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        nv = n_valid;
        ne = n_err;
        send_frame(8'h5A, 1'b1, 1'b1, 11, -1);
        wait_cyc(5);
        check("after_rst_valid", n_valid - nv, 1);
        check("after_rst_err", n_err - ne, 0);
        check("after_rst_rx_data", rx_data, 8'h5A);

        check("valid_err_exclusive", n_both, 0);
        check("pulse_width_one", n_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host receiver. It sits directly upstream of ps2ctrlr's scancode handling.
- Synchronises and de-glitches the raw PS2_CLK/PS2_DAT pins and deserialises 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Delivers each byte as a one-cycle strobe, or reports a classified error.
- Runs entirely in the CLOCK_50 domain. The PS/2 clock is only ever sampled as data, never used as a clock.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TIMEOUT_US, 2000, maximum gap between falling PS/2 clock edges within a frame, in µs.
- SYNC_STAGES, 2, flip-flops in each pin synchroniser (≥2).
- GLITCH_CYCLES, 8, consecutive identical synchronised samples required before the filtered level changes.

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- PS2_CLK  in  1  raw PS/2 clock pin.
- PS2_DAT  in  1  raw PS/2 data pin.
- rx_data  out  8  last good byte; holds until the next good byte.
- rx_valid  out  1  one-cycle pulse: rx_data has just been updated.
- rx_err  out  1  one-cycle pulse: frame aborted or rejected.
- err_code  out  2  error class: 0 none, 1 parity, 2 stop, 3 timeout. Holds until the next rx_err or rx_valid.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Clock and reset: single clock CLOCK_50. Reset is asynchronous and active-high on RESET.
- Reset values:
  - rx_data=0, rx_valid=0, rx_err=0, err_code=0, busy=0.
  - Synchroniser and filter outputs reset to 1 (idle bus level), so no false falling edge is produced on release.
  - Bit counter, shift register and timeout counter reset to 0; state resets to IDLE.
- Filter:
  - The filtered level changes only after GLITCH_CYCLES consecutive synchronised samples differ from it. Shorter pulses are ignored.
  - fall = previous filtered clock 1 and current filtered clock 0.
  - Data is taken from the filtered PS2_DAT in the same cycle as fall.
- Latency: pin edge to fall pulse = SYNC_STAGES + GLITCH_CYCLES cycles (±1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA and clear the bit counter. On fall with data=1 (bad start bit), stay in IDLE; no error is reported.
  - DATA: on each fall, shift data into bit 7 of the shift register (shift right). After the 8th bit, go to PARITY.
  - PARITY: on fall, record perr = ~(^{shift,data}), i.e. the 9 bits must contain an odd number of ones. Go to STOP.
  - STOP: on fall, return to IDLE. In the following cycle:
    - if perr: rx_err=1, err_code=1;
    - else if data=0: rx_err=1, err_code=2;
    - else: rx_data=shift, rx_valid=1, err_code=0.
  - Parity error takes precedence over stop error.
- Timeout:
  - The counter clears on every fall and counts while state != IDLE.
  - When it reaches TCYC = CLK_HZ/1_000_000*TIMEOUT_US (100000 at defaults), go to IDLE. In the next cycle: rx_err=1, err_code=3.
  - Counter width is $clog2(TCYC+1). The counter saturates and never wraps.
- rx_valid and rx_err are mutually exclusive and each is exactly one cycle wide.
- A fall arriving in the same cycle as the timeout: the timeout wins, and the fall is discarded.
- RESET asserted mid-frame aborts the frame immediately. No error is reported, and rx_data reverts to 0.
- Back-to-back frames: a start bit on the fall immediately after the STOP fall is accepted.
- Sampling is from the filtered signals only. The design never drives the PS/2 pins; host-to-device transfers are out of scope.

Decomposition:
- ps2_pkg contains:
  - typedef enum logic [1:0] ps2_rx_state_t {IDLE, DATA, PARITY, STOP};
  - typedef enum logic [1:0] ps2_err_t {ERR_NONE, ERR_PARITY, ERR_STOP, ERR_TIMEOUT};
  - localparam PS2_FRAME_BITS = 11.
- One sub-module, ps2_in_filter (synchroniser plus glitch filter), with parameters SYNC_STAGES and GLITCH_CYCLES. It is instantiated twice, once for the clock pin and once for the data pin.
- ps2_rx contains the edge detect, FSM, shift register and timeout counter.

Test Plan:
- Good frame: send 0x1C at 12.5 kHz (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) → exactly one rx_valid pulse; rx_data=0x1C; err_code=0; busy low after the stop bit.
- Parity error: 0x1C with parity bit 1 → one rx_err pulse; err_code=1; no rx_valid; rx_data keeps its previous value.
- Stop error: 0x1C with good parity and stop bit 0 → rx_err with err_code=2, no rx_valid.
- Timeout then recovery: send start plus 4 data bits, then hold PS2_CLK high for 2.1 ms → rx_err with err_code=3, 100000 cycles (±1) after the last fall, and busy=0. Then send 0xF0 with parity 1 → rx_valid with rx_data=0xF0.
- Glitch rejection: while idle, a 5-cycle low pulse on PS2_CLK, and a 5-cycle pulse on PS2_DAT during a data bit → busy stays 0 for the idle pulse, and the frame still decodes correctly.
- Reset mid-frame: assert RESET after 4 data bits of 0x1C → all outputs are 0 immediately. After release, send 0x5A with parity 1 → rx_valid with rx_data=0x5A and no rx_err.
